gpu_ram_responder: RTL and testbench

Responder end of the GPU RAM command interface. Accepts the one-command-per-clock stream issued by the Z80/RS232/geometry arbitration mux (write strobe, 8/16-bit select, 20-bit byte address, 16-bit data) and executes it against an internal byte-addressed RAM. The RAM is built as two 8-bit banks (even/odd bytes), so any 8- or 16-bit access, aligned or not, completes in one RAM cycle. Read data returns at a fixed latency matching the mux's `READ_CLOCK_CYCLES`, so the mux needs no handshake back.

---
 rtl/gpu_ram_responder.sv | 146 ++++++++++++++
 tb/tb_gpu_ram_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/gpu_ram_responder.sv
// -----------------------------------------------------------------------------
// gpu_ram_responder
//
// Responder end of the GPU RAM command interface. Executes one command per
// clock against a byte-addressed RAM built from two 8-bit banks (even / odd
// bytes). Because the two bytes of any 16-bit access always fall in different
// banks, aligned and unaligned accesses both complete in one RAM cycle. Read
// data returns at a fixed latency of READ_CLOCK_CYCLES with no handshake.
//
// Parameters:
//   READ_CLOCK_CYCLES  command-to-data latency, 2..8
//   MEM_ADDR_BITS      implemented byte address bits, 2..20 (upper bits alias)
//
// Ports:
//   clk            system clock
//   reset          synchronous reset, active low
//   gpu_wr_ena     write strobe (one cycle per write)
//   gpu_rd_req     read strobe (one cycle per read)
//   gpu_ena_16bit  1 = 16-bit access, 0 = 8-bit access
//   gpu_address    byte address A
//   gpu_data_out   write data: [7:0] -> byte A, [15:8] -> byte A+1 (16-bit)
//   gpu_data_in    read data {byte A+1, byte A}, held between reads
//   gpu_rd_valid   one-cycle pulse when gpu_data_in carries a new result
// -----------------------------------------------------------------------------
module gpu_ram_responder #(
  parameter int READ_CLOCK_CYCLES = 2,
  parameter int MEM_ADDR_BITS     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gpu_wr_ena,
  input  logic        gpu_rd_req,
  input  logic        gpu_ena_16bit,
  input  logic [19:0] gpu_address,
  input  logic [15:0] gpu_data_out,
  output logic [15:0] gpu_data_in,
  output logic        gpu_rd_valid
);

  localparam int IDX_BITS = MEM_ADDR_BITS - 1;
  localparam int WORDS    = 2 ** IDX_BITS;
  // Stage 0 of the delay line is the output register fed by the RAM read;
  // the remaining stages pad the latency out to READ_CLOCK_CYCLES.
  localparam int DEPTH    = READ_CLOCK_CYCLES - 1;

  typedef struct packed {
    logic                wr_even;
    logic                wr_odd;
    logic                rd;
    logic                lane;      // A[0]: 1 means byte A sits in the odd bank
    logic [IDX_BITS-1:0] idx_even;
    logic [IDX_BITS-1:0] idx_odd;
    logic [7:0]          data_even;
    logic [7:0]          data_odd;
  } stage1_t;

  stage1_t s1, s1_next;

  logic [MEM_ADDR_BITS-1:0] addr_lo;
  logic [MEM_ADDR_BITS-1:0] addr_hi;

  // Upper address bits beyond the implemented RAM are deliberately ignored.
  generate
    if (MEM_ADDR_BITS < 20) begin : g_alias
      logic unused_high;
      assign unused_high = ^gpu_address[19:MEM_ADDR_BITS];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stage 1: address steering and lane routing
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in always_comb gets a default first so no path
  // leaves it unassigned; that is what keeps this block free of latches.
  always_comb begin
    s1_next = '0;
    addr_lo = gpu_address[MEM_ADDR_BITS-1:0];
    addr_hi = addr_lo + MEM_ADDR_BITS'(1);  // wraps to byte 0 at the top

    s1_next.lane     = addr_lo[0];
    s1_next.rd       = gpu_rd_req;
    s1_next.idx_odd  = addr_lo[MEM_ADDR_BITS-1:1];
    s1_next.idx_even = addr_lo[0] ? addr_hi[MEM_ADDR_BITS-1:1]
                                  : addr_lo[MEM_ADDR_BITS-1:1];

    // Byte A always goes to the bank named by A[0]; byte A+1 to the other.
    s1_next.wr_even  = gpu_wr_ena & (gpu_ena_16bit | ~addr_lo[0]);
    s1_next.wr_odd   = gpu_wr_ena & (gpu_ena_16bit |  addr_lo[0]);
    s1_next.data_even = addr_lo[0] ? gpu_data_out[15:8] : gpu_data_out[7:0];
    s1_next.data_odd  = addr_lo[0] ? gpu_data_out[7:0]  : gpu_data_out[15:8];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its inputs as they stood before the clock edge.
  always_ff @(posedge clk) begin
    if (!reset) s1 <= '0;
    else        s1 <= s1_next;
  end

  // ---------------------------------------------------------------------------
  // Bank RAMs
  // ---------------------------------------------------------------------------
  logic [7:0] mem_even [WORDS];
  logic [7:0] mem_odd  [WORDS];

  // NOTE: the RAM arrays have no reset so they map onto block RAM and keep
  // their contents across reset; only the stage-1 write is gated by reset.
  always_ff @(posedge clk) begin
    if (reset && s1.wr_even) mem_even[s1.idx_even] <= s1.data_even;
    if (reset && s1.wr_odd)  mem_odd[s1.idx_odd]   <= s1.data_odd;
  end

  // Reassemble {byte A+1, byte A}. The read samples the arrays before this
  // edge's write lands, giving read-before-write for a same-cycle command.
  logic [15:0] rd_word;
  always_comb begin
    rd_word = '0;
    if (s1.lane) rd_word = {mem_even[s1.idx_even], mem_odd[s1.idx_odd]};
    else         rd_word = {mem_odd[s1.idx_odd],   mem_even[s1.idx_even]};
  end

  // ---------------------------------------------------------------------------
  // Output register plus latency padding; data moves only with a valid read
  // so the final stage holds its value between results.
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0] pipe_valid;
  logic [15:0]      pipe_data [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < DEPTH; i++) pipe_data[i] <= '0;
    end else begin
      pipe_valid[0] <= s1.rd;
      if (s1.rd) pipe_data[0] <= rd_word;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  assign gpu_data_in  = pipe_data[DEPTH-1];
  assign gpu_rd_valid = pipe_valid[DEPTH-1];

endmodule

// File: tb/tb_gpu_ram_responder.sv
// -----------------------------------------------------------------------------
// tb_gpu_ram_responder
//
// Drives one command stream into three responders (latency 2, 3 and 4) and
// checks each against a byte-level memory model. Expected read results are
// queued when a read is issued and consumed as each instance reports a valid.
// -----------------------------------------------------------------------------
module tb_gpu_ram_responder;

  localparam int NDUT = 3;
  localparam int RCC [NDUT] = '{2, 3, 4};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        gpu_wr_ena = 1'b0;
  logic        gpu_rd_req = 1'b0;
  logic        gpu_ena_16bit = 1'b0;
  logic [19:0] gpu_address = '0;
  logic [15:0] gpu_data_out = '0;

  logic [15:0] dout [NDUT];
  logic        vld  [NDUT];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  gpu_ram_responder #(.READ_CLOCK_CYCLES(2), .MEM_ADDR_BITS(16)) u_dut2 (
    .clk(clk), .reset(reset), .gpu_wr_ena(gpu_wr_ena), .gpu_rd_req(gpu_rd_req),
    .gpu_ena_16bit(gpu_ena_16bit), .gpu_address(gpu_address),
    .gpu_data_out(gpu_data_out), .gpu_data_in(dout[0]), .gpu_rd_valid(vld[0]));

  gpu_ram_responder #(.READ_CLOCK_CYCLES(3), .MEM_ADDR_BITS(16)) u_dut3 (
    .clk(clk), .reset(reset), .gpu_wr_ena(gpu_wr_ena), .gpu_rd_req(gpu_rd_req),
    .gpu_ena_16bit(gpu_ena_16bit), .gpu_address(gpu_address),
    .gpu_data_out(gpu_data_out), .gpu_data_in(dout[1]), .gpu_rd_valid(vld[1]));

  gpu_ram_responder #(.READ_CLOCK_CYCLES(4), .MEM_ADDR_BITS(16)) u_dut4 (
    .clk(clk), .reset(reset), .gpu_wr_ena(gpu_wr_ena), .gpu_rd_req(gpu_rd_req),
    .gpu_ena_16bit(gpu_ena_16bit), .gpu_address(gpu_address),
    .gpu_data_out(gpu_data_out), .gpu_data_in(dout[2]), .gpu_rd_valid(vld[2]));

  // ---------------------------------------------------------------------------
  // Checking and scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic [15:0] mask;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t sb [$];
  int   ptr [NDUT] = '{0, 0, 0};
  logic [7:0] model [65536];

  exp_t mon_e;
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (vld[d] === 1'b1) begin
        if (ptr[d] >= sb.size()) begin
          check($sformatf("unexpected_valid_rcc%0d", RCC[d]), 32'd1, 32'd0);
        end else begin
          mon_e = sb[ptr[d]];
          check($sformatf("%s_rcc%0d", mon_e.tag, RCC[d]),
                32'(dout[d] & mon_e.mask), 32'(mon_e.data & mon_e.mask));
          check($sformatf("%s_latency_rcc%0d", mon_e.tag, RCC[d]),
                32'(cyc - mon_e.cyc), 32'(RCC[d]));
          ptr[d]++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic issue(input logic wr, input logic rd, input logic b16,
                       input logic [19:0] addr, input logic [15:0] data,
                       input string tag);
    exp_t        e;
    logic [15:0] a;
    logic [15:0] a1;
    @(posedge clk); #1;
    gpu_wr_ena    = wr;
    gpu_rd_req    = rd;
    gpu_ena_16bit = b16;
    gpu_address   = addr;
    gpu_data_out  = data;
    a  = addr[15:0];
    a1 = a + 16'd1;
    if (rd) begin
      e.data = {model[a1], model[a]};
      e.mask = b16 ? 16'hFFFF : 16'h00FF;
      e.cyc  = cyc;
      e.tag  = tag;
      sb.push_back(e);
    end
    if (wr) begin
      model[a] = data[7:0];
      if (b16) model[a1] = data[15:8];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      gpu_wr_ena = 1'b0;
      gpu_rd_req = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 65536; i++) model[i] = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("reset_data_rcc%0d", RCC[d]), 32'(dout[d]), 32'h0);
      check($sformatf("reset_valid_rcc%0d", RCC[d]), 32'(vld[d]), 32'h0);
    end
    @(posedge clk); #1;
    reset = 1'b1;

    // Two byte writes then a 16-bit read of the pair.
    issue(1, 0, 0, 20'h00010, 16'hFF5A, "wr10");
    issue(1, 0, 0, 20'h00011, 16'h00C3, "wr11");
    issue(0, 1, 1, 20'h00010, 16'h0000, "rd16_0010");
    idle(6);

    // Unaligned 16-bit write with neighbours pre-set.
    issue(1, 0, 0, 20'h00020, 16'h0011, "wr20");
    issue(1, 0, 0, 20'h00023, 16'h0044, "wr23");
    issue(1, 0, 1, 20'h00021, 16'hBEEF, "wr21_16");
    issue(0, 1, 1, 20'h00021, 16'h0000, "rd16_0021");
    issue(0, 1, 0, 20'h00021, 16'h0000, "rd8_0021");
    issue(0, 1, 0, 20'h00022, 16'h0000, "rd8_0022");
    issue(0, 1, 0, 20'h00020, 16'h0000, "rd8_0020");
    issue(0, 1, 0, 20'h00023, 16'h0000, "rd8_0023");
    idle(6);

    // Top-of-memory wrap and upper-bit aliasing.
    issue(1, 0, 1, 20'h0FFFF, 16'h1234, "wr_wrap");
    issue(0, 1, 1, 20'h0FFFF, 16'h0000, "rd_wrap");
    issue(0, 1, 0, 20'h00000, 16'h0000, "rd8_0000");
    issue(1, 0, 0, 20'h10005, 16'h0077, "wr_alias");
    issue(0, 1, 0, 20'h00005, 16'h0000, "rd_alias");
    idle(6);

    // Write-then-read and read-then-write ordering, plus same-cycle both.
    issue(1, 0, 0, 20'h00200, 16'h003C, "wr200_init");
    issue(1, 0, 0, 20'h00300, 16'h0099, "wr300_init");
    idle(2);
    issue(1, 0, 0, 20'h00100, 16'h00AA, "wr100");
    issue(0, 1, 0, 20'h00100, 16'h0000, "raw_0100");
    issue(0, 1, 0, 20'h00200, 16'h0000, "war_0200");
    issue(1, 0, 0, 20'h00200, 16'h0055, "wr200");
    issue(1, 1, 0, 20'h00300, 16'h0066, "rw_same_0300");
    issue(0, 1, 0, 20'h00200, 16'h0000, "rd200_new");
    issue(0, 1, 0, 20'h00300, 16'h0000, "rd300_new");
    idle(6);

    // Back-to-back reads across bytes 0..7.
    for (int i = 0; i < 10; i += 2)
      issue(1, 0, 1, 20'(i), 16'({8'(8'h81 + i), 8'(8'h80 + i)}), "wr_seq");
    for (int i = 0; i < 8; i++)
      issue(0, 1, 1, 20'(i), 16'h0000, $sformatf("seq_rd%0d", i));
    idle(8);

    // Reset while a read is in flight; a write presented during reset is ignored.
    issue(0, 1, 1, 20'h00010, 16'h0000, "rd_dropped");
    @(posedge clk); #1;
    gpu_wr_ena    = 1'b1;
    gpu_rd_req    = 1'b0;
    gpu_ena_16bit = 1'b1;
    gpu_address   = 20'h00010;
    gpu_data_out  = 16'hDEAD;
    reset         = 1'b0;
    @(posedge clk); #1;
    reset      = 1'b1;
    gpu_wr_ena = 1'b0;
    for (int d = 0; d < NDUT; d++) ptr[d] = sb.size();
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("post_reset_data_rcc%0d", RCC[d]), 32'(dout[d]), 32'h0);
      check($sformatf("post_reset_valid_rcc%0d", RCC[d]), 32'(vld[d]), 32'h0);
    end
    idle(6);
    issue(0, 1, 1, 20'h00010, 16'h0000, "rd_after_reset_0010");
    issue(0, 1, 1, 20'h00021, 16'h0000, "rd_after_reset_0021");
    idle(10);

    for (int d = 0; d < NDUT; d++)
      check($sformatf("drained_rcc%0d", RCC[d]), 32'(ptr[d]), 32'(sb.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
